// File: rtl/reg_serial_loader_if.sv
// Serial host link plus register-write strobe bundle for reg_serial_loader.
// master = host/consumer side, slave = the loader itself.
interface reg_serial_loader_if;
   logic        SCLK;
   logic        SDI;
   logic        CS_N;
   logic [3:0]  Addr;
   logic [11:0] Dout;
   logic        EN;
   logic        EN_DC;
   logic        EN_AMP;
   logic        EN_FREQ;
   logic        FrameErr;

   modport master (
      output SCLK, SDI, CS_N,
      input  Addr, Dout, EN, EN_DC, EN_AMP, EN_FREQ, FrameErr
   );

   modport slave (
      input  SCLK, SDI, CS_N,
      output Addr, Dout, EN, EN_DC, EN_AMP, EN_FREQ, FrameErr
   );
endinterface

// File: rtl/reg_serial_loader.sv
// Oversampling serial register loader: 16-bit {addr[3:0], data[11:0]} frames -> one-cycle write strobes.
// Optional build macro WR_PARITY_EN adds a trailing even-parity bit (17-bit frames).
module reg_serial_loader #(
   parameter logic [3:0] DC_ADDR   = 4'h0,
   parameter logic [3:0] AMP_ADDR  = 4'h1,
   parameter logic [3:0] FREQ_ADDR = 4'h2
) (
   input logic                Clock,
   input logic                Reset,
   reg_serial_loader_if.slave bus
);

`ifdef WR_PARITY_EN
   localparam int unsigned FRAME_BITS = 17;
`else
   localparam int unsigned FRAME_BITS = 16;
`endif
   localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_MAX   = 5'd31;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

`ifdef WR_PARITY_EN
   function automatic logic par_fold(input logic acc, input logic b);
      return acc ^ b;
   endfunction
`endif

   // Pipelines: bit0 = sync stage 1, bit1 = sync stage 2, bit2 = edge history.
   logic [2:0] sclk_pipe_q, sclk_pipe_d;
   logic [1:0] sdi_pipe_q,  sdi_pipe_d;
   logic [2:0] cs_pipe_q,   cs_pipe_d;

   logic [1:0]            state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [4:0]            cnt_q,   cnt_d;
   logic [3:0]            addr_q,  addr_d;
   logic [11:0]           dout_q,  dout_d;
   logic                  en_q,    en_d;
   logic                  en_dc_q, en_dc_d;
   logic                  en_amp_q, en_amp_d;
   logic                  en_freq_q, en_freq_d;
   logic                  err_q,   err_d;
`ifdef WR_PARITY_EN
   logic                  par_q,   par_d;
`endif

   logic sclk_rise;
   logic cs_rise;
   logic cs_fall;
   logic cs_low_steady;
   logic sdi_bit;
   logic frame_ok;

   assign sclk_rise     =  sclk_pipe_q[1] & ~sclk_pipe_q[2];
   assign cs_rise       =  cs_pipe_q[1]   & ~cs_pipe_q[2];
   assign cs_fall       = ~cs_pipe_q[1]   &  cs_pipe_q[2];
   assign cs_low_steady = ~cs_pipe_q[1]   & ~cs_pipe_q[2];
   assign sdi_bit       =  sdi_pipe_q[1];

`ifdef WR_PARITY_EN
   assign frame_ok = (cnt_q == FRAME_LEN) && (par_q == 1'b0);
`else
   assign frame_ok = (cnt_q == FRAME_LEN);
`endif

   // Synchronizer and edge-history shifting.
   always_comb begin
      sclk_pipe_d = {sclk_pipe_q[1:0], bus.SCLK};
      sdi_pipe_d  = {sdi_pipe_q[0],    bus.SDI};
      cs_pipe_d   = {cs_pipe_q[1:0],   bus.CS_N};
   end

   // Frame FSM, shift register, counter and output strobes.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      en_d    = 1'b0;
      err_d   = 1'b0;
`ifdef WR_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               shift_d = '0;
               cnt_d   = 5'd0;
`ifdef WR_PARITY_EN
               par_d   = 1'b0;
`endif
               state_d = ST_SHIFT;
            end else if (cs_low_steady) begin
               // CS_N can only look steadily low in IDLE right after reset release.
               state_d = ST_ABORT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               if (frame_ok) begin
                  en_d   = 1'b1;
                  addr_d = shift_q[FRAME_BITS-1 -: 4];
                  dout_d = shift_q[FRAME_BITS-5 -: 12];
               end else begin
                  err_d  = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_d = {shift_q[FRAME_BITS-2:0], sdi_bit};
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;
`ifdef WR_PARITY_EN
               par_d   = par_fold(par_q, sdi_bit);
`endif
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_ABORT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ABORT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      en_dc_d   = en_d && (addr_d == DC_ADDR);
      en_amp_d  = en_d && (addr_d == AMP_ADDR);
      en_freq_d = en_d && (addr_d == FREQ_ADDR);
   end

   // State registers; CS_N sync resets low so a frame in flight at release lands in ABORT.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sclk_pipe_q <= 3'b000;
         sdi_pipe_q  <= 2'b00;
         cs_pipe_q   <= 3'b000;
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         cnt_q       <= 5'd0;
         addr_q      <= 4'h0;
         dout_q      <= 12'h000;
         en_q        <= 1'b0;
         en_dc_q     <= 1'b0;
         en_amp_q    <= 1'b0;
         en_freq_q   <= 1'b0;
         err_q       <= 1'b0;
`ifdef WR_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         sclk_pipe_q <= sclk_pipe_d;
         sdi_pipe_q  <= sdi_pipe_d;
         cs_pipe_q   <= cs_pipe_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         en_q        <= en_d;
         en_dc_q     <= en_dc_d;
         en_amp_q    <= en_amp_d;
         en_freq_q   <= en_freq_d;
         err_q       <= err_d;
`ifdef WR_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign bus.Addr     = addr_q;
   assign bus.Dout     = dout_q;
   assign bus.EN       = en_q;
   assign bus.EN_DC    = en_dc_q;
   assign bus.EN_AMP   = en_amp_q;
   assign bus.EN_FREQ  = en_freq_q;
   assign bus.FrameErr = err_q;

endmodule

// File: tb/tb_reg_serial_loader.sv
// Self-checking bench for reg_serial_loader: table vectors, hand-written corner sequences,
// and randomized frames against a frame-level reference model.
module tb_reg_serial_loader;

   logic Clock;
   logic Reset;
   reg_serial_loader_if bus();

   reg_serial_loader dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int en_seen = 0;
   int err_seen = 0;
   int exp_en_total = 0;
   int exp_err_total = 0;
   logic [3:0]  m_addr = 4'h0;
   logic [11:0] m_dout = 12'h000;

   typedef struct {
      logic [15:0] payload;
      int          adj;
      bit          en;
      bit          err;
      logic [3:0]  addr;
      logic [11:0] dout;
      bit          dc;
      bit          amp;
      bit          freq;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobe monitor, sampled away from the active edge.
   always @(negedge Clock) begin
      if (bus.EN === 1'b1) en_seen++;
      if (bus.FrameErr === 1'b1) err_seen++;
      if (bus.EN === 1'b1 && bus.FrameErr === 1'b1) begin
         errors++;
         $display("FAIL en_and_err: both strobes high at %0t", $time);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic shift_bit(input bit b);
      bus.SDI = b;
      repeat (2) @(posedge Clock);
      #1 bus.SCLK = 1'b1;
      repeat (4) @(posedge Clock);
      #1 bus.SCLK = 1'b0;
      repeat (2) @(posedge Clock);
   endtask

   task automatic start_frame();
      @(posedge Clock);
      #1 bus.CS_N = 1'b0;
      repeat (4) @(posedge Clock);
   endtask

   // Frame body: payload MSB first, optional parity bit, then length adjusted by adj.
   task automatic send_body(input logic [15:0] payload, input int adj, input bit flip);
      bit bits[$];
      for (int i = 15; i >= 0; i--) bits.push_back(payload[i]);
`ifdef WR_PARITY_EN
      bits.push_back((^payload) ^ flip);
`endif
      if (adj < 0) begin
         for (int i = 0; i < -adj; i++) void'(bits.pop_back());
      end else begin
         for (int i = 0; i < adj; i++) bits.push_back(1'b0);
      end
      foreach (bits[i]) shift_bit(bits[i]);
   endtask

   // Raise CS_N just after an edge so edge k is the next one; strobe must appear on k+2 only.
   task automatic close_and_check(input string tag, input bit e_en, input bit e_err,
                                  input logic [3:0] ea, input logic [11:0] ed,
                                  input bit edc, input bit eamp, input bit efreq);
      @(posedge Clock);
      #1 bus.CS_N = 1'b1;
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      check({tag, "_early"}, {bus.EN, bus.FrameErr}, 2'b00);
      @(posedge Clock);
      @(negedge Clock);
      check({tag, "_strobe"}, {bus.EN, bus.FrameErr, bus.EN_DC, bus.EN_AMP, bus.EN_FREQ},
            {e_en, e_err, edc, eamp, efreq});
      check({tag, "_addr"}, bus.Addr, ea);
      check({tag, "_dout"}, bus.Dout, ed);
      @(negedge Clock);
      check({tag, "_clear"}, {bus.EN, bus.FrameErr, bus.EN_DC, bus.EN_AMP, bus.EN_FREQ}, 5'b0);
      check({tag, "_hold"}, {bus.Addr, bus.Dout}, {ea, ed});
      if (e_en) begin
         exp_en_total++;
         m_addr = ea;
         m_dout = ed;
      end
      if (e_err) exp_err_total++;
   endtask

   // Reference model: accept iff nominal length and intact parity; decode from payload.
   task automatic model_frame(input string tag, input logic [15:0] payload, input int adj, input bit flip);
      bit acc;
      logic [3:0] a;
      acc = (adj == 0) && !flip;
      a = payload[15:12];
      start_frame();
      send_body(payload, adj, flip);
      if (acc) close_and_check(tag, 1'b1, 1'b0, a, payload[11:0],
                               a == 4'h0, a == 4'h1, a == 4'h2);
      else     close_and_check(tag, 1'b0, 1'b1, m_addr, m_dout, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int snap;
      tbl[0] = '{16'h0ABC,  0, 1'b1, 1'b0, 4'h0, 12'hABC, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{16'h1123,  0, 1'b1, 1'b0, 4'h1, 12'h123, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{16'h2FFF,  0, 1'b1, 1'b0, 4'h2, 12'hFFF, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{16'h5A5A, -1, 1'b0, 1'b1, 4'h2, 12'hFFF, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{16'h3C3C,  1, 1'b0, 1'b1, 4'h2, 12'hFFF, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{16'h7001,  0, 1'b1, 1'b0, 4'h7, 12'h001, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{16'hF000,  0, 1'b1, 1'b0, 4'hF, 12'h000, 1'b0, 1'b0, 1'b0};

      bus.SCLK = 1'b0;
      bus.SDI  = 1'b0;
      bus.CS_N = 1'b1;
      Reset    = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("reset_outputs", {bus.Addr, bus.Dout, bus.EN, bus.FrameErr, bus.EN_DC, bus.EN_AMP, bus.EN_FREQ},
            23'd0);
      @(posedge Clock);
      #1 Reset = 1'b1;
      repeat (6) @(posedge Clock);
      @(negedge Clock);
      check("post_release_quiet", {bus.Addr, bus.Dout, bus.EN, bus.FrameErr}, 18'd0);

      for (int i = 0; i < 7; i++) begin
         start_frame();
         send_body(tbl[i].payload, tbl[i].adj, 1'b0);
         close_and_check($sformatf("vec%0d", i), tbl[i].en, tbl[i].err, tbl[i].addr, tbl[i].dout,
                         tbl[i].dc, tbl[i].amp, tbl[i].freq);
      end

      // Reset after 8 bits, release with CS_N still low, finish the frame: no strobe.
      start_frame();
      for (int i = 15; i >= 8; i--) shift_bit(1'b1);
      @(posedge Clock);
      #1 Reset = 1'b0;
      #2;
      check("midframe_reset_clear", {bus.Addr, bus.Dout, bus.EN, bus.FrameErr}, 18'd0);
      m_addr = 4'h0;
      m_dout = 12'h000;
      @(posedge Clock);
      #1 Reset = 1'b1;
      snap = en_seen + err_seen;
      for (int i = 7; i >= 0; i--) shift_bit(1'b0);
      @(posedge Clock);
      #1 bus.CS_N = 1'b1;
      repeat (6) @(posedge Clock);
      @(negedge Clock);
      check("aborted_no_strobe", en_seen + err_seen, snap);
      check("aborted_hold", {bus.Addr, bus.Dout}, 16'h0000);
      model_frame("after_abort", 16'h0555, 0, 1'b0);

      // SCLK activity with CS_N high must be ignored.
      snap = en_seen + err_seen;
      for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)));
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      check("idle_sclk_no_strobe", en_seen + err_seen, snap);
      model_frame("unmapped_7001", 16'h7001, 0, 1'b0);

`ifdef WR_PARITY_EN
      model_frame("par_good", 16'h0ABC, 0, 1'b0);
      model_frame("par_bad", 16'h0ABC, 0, 1'b1);
      model_frame("par_bad2", 16'h1777, 0, 1'b1);
`endif

      for (int n = 0; n < 30; n++) begin
         logic [15:0] p;
         int r;
         int adj;
         bit flip;
         p = 16'($urandom);
         if (n % 5 == 0) p[15:12] = 4'($urandom_range(0, 2));
         r = $urandom_range(0, 7);
         adj = (r < 4) ? 0 : (r == 4) ? -1 : (r == 5) ? 1 : (r == 6) ? -2 : 2;
         flip = 1'b0;
`ifdef WR_PARITY_EN
         flip = ($urandom_range(0, 3) == 0);
`endif
         model_frame($sformatf("rnd%0d", n), p, adj, flip);
      end

      repeat (4) @(posedge Clock);
      @(negedge Clock);
      check("en_total", en_seen, exp_en_total);
      check("err_total", err_seen, exp_err_total);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
